// File: rtl/uart_tx_feeder.sv
// Elastic byte FIFO between the UART receiver and transmitter: captures each completed Rx byte
// and replays it to Tx with a request/busy handshake, so echoed bursts are not lost.
module uart_tx_feeder #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned SEND_TIMEOUT = 65535
) (
  input  logic                src_clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_bussy,
  input  logic                tx_bussy,
  input  logic                clear_err,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_send,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                tx_timeout
);

  localparam int unsigned Depth       = 2 ** DEPTH_LOG2;
  localparam int unsigned TimerW      = $clog2(SEND_TIMEOUT + 1);
  localparam int unsigned TimeoutLast = SEND_TIMEOUT - 1;

  localparam logic [DEPTH_LOG2:0]   CountFull = Depth[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CountOne  = 1;
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = 1;
  localparam logic [TimerW-1:0]     TimerLast = TimeoutLast[TimerW-1:0];
  localparam logic [TimerW-1:0]     TimerOne  = 1;

  typedef enum logic [1:0] {StIdle, StReq, StBusy} state_e;

  state_e                state_q, state_d;
  logic                  rxb_meta_q, rxb_meta_d, rxb_s_q, rxb_s_d, rxb_prev_q, rxb_prev_d;
  logic                  txb_meta_q, txb_meta_d, txb_s_q, txb_s_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DATA_W-1:0]     mem_q [Depth];
  logic [DATA_W-1:0]     mem_d [Depth];
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  logic                  tx_send_q, tx_send_d;
  logic                  overflow_q, overflow_d, tx_timeout_q, tx_timeout_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic                  push_req, push, pop, ovf_evt, timeout_evt;

  assign empty = (count_q == '0);
  assign full  = (count_q == CountFull);

  always_comb begin
    rxb_meta_d = rx_bussy;
    rxb_s_d    = rxb_meta_q;
    rxb_prev_d = rxb_s_q;
    txb_meta_d = tx_bussy;
    txb_s_d    = txb_meta_q;

    // A falling edge of the synchronised Rx busy flag marks a completed byte
    push_req = rxb_prev_q & ~rxb_s_q & ena;
    pop      = (state_q == StIdle) & ~empty & ena & ~txb_s_q;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands
    push     = push_req & (~full | pop);
    ovf_evt  = push_req & ~push;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = rx_data;
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase

    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_send_d   = tx_send_q;
    timer_d     = timer_q;
    timeout_evt = 1'b0;
    case (state_q)
      StIdle: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          tx_send_d = 1'b1;
          timer_d   = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (txb_s_q) begin
          tx_send_d = 1'b0;
          state_d   = StBusy;
        end else if (timer_q == TimerLast) begin
          tx_send_d   = 1'b0;
          timeout_evt = 1'b1;
          state_d     = StIdle;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      StBusy: begin
        if (!txb_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    overflow_d   = (overflow_q & ~clear_err) | ovf_evt;
    tx_timeout_d = (tx_timeout_q & ~clear_err) | timeout_evt;
  end

  always_ff @(posedge src_clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rxb_meta_q   <= 1'b0;
      rxb_s_q      <= 1'b0;
      rxb_prev_q   <= 1'b0;
      txb_meta_q   <= 1'b0;
      txb_s_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tx_data_q    <= '0;
      tx_send_q    <= 1'b0;
      timer_q      <= '0;
      overflow_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rxb_meta_q   <= rxb_meta_d;
      rxb_s_q      <= rxb_s_d;
      rxb_prev_q   <= rxb_prev_d;
      txb_meta_q   <= txb_meta_d;
      txb_s_q      <= txb_s_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tx_data_q    <= tx_data_d;
      tx_send_q    <= tx_send_d;
      timer_q      <= timer_d;
      overflow_q   <= overflow_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone
  always_ff @(posedge src_clk) begin
    mem_q <= mem_d;
  end

  assign tx_data    = tx_data_q;
  assign tx_send    = tx_send_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign tx_timeout = tx_timeout_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed-plus-random bench for uart_tx_feeder; a byte queue stands in for the FIFO and the
// expected send order, flags are tracked as plain bits.
module tb_uart_tx_feeder;

  localparam int unsigned Timeout = 20;

  logic       src_clk = 1'b0;
  logic       rst_n, ena, rx_bussy, tx_bussy, clear_err;
  logic [7:0] rx_data, tx_data;
  logic       tx_send, empty, full, overflow, tx_timeout;
  logic [4:0] count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q[$];
  logic        exp_ovf, exp_to;

  always #5 src_clk = ~src_clk;

  uart_tx_feeder #(
    .DATA_W      (8),
    .DEPTH_LOG2  (4),
    .SEND_TIMEOUT(Timeout)
  ) dut (
    .src_clk   (src_clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rx_data   (rx_data),
    .rx_bussy  (rx_bussy),
    .tx_bussy  (tx_bussy),
    .clear_err (clear_err),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .tx_timeout(tx_timeout)
  );

  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (!ena) return;
    if (exp_q.size() == 16) exp_ovf = 1'b1;
    else exp_q.push_back(b);
  endtask

  // Rx byte: busy high, then fall; clr optionally pulses clear_err on the capture edge
  task automatic push_byte(input logic [7:0] b, input logic clr);
    rx_data  = b;
    rx_bussy = 1'b1;
    repeat (4) tick();
    rx_bussy = 1'b0;
    tick();
    tick();
    clear_err = clr;
    tick();
    clear_err = 1'b0;
    tick();
    if (clr) begin
      exp_ovf = 1'b0;
      exp_to  = 1'b0;
    end
    model_push(b);
  endtask

  task automatic wait_send(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (tx_send !== lvl && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(tx_send), 32'(lvl));
  endtask

  task automatic drain_one();
    logic [7:0] e;
    e = exp_q.pop_front();
    tx_bussy = 1'b0;
    wait_send(1'b1, 10, "send_start");
    check("tx_data", 32'(tx_data), 32'(e));
    check("count_after_pop", 32'(count), 32'(exp_q.size()));
    tx_bussy = 1'b1;
    wait_send(1'b0, 6, "send_ack");
    check("tx_data_hold", 32'(tx_data), 32'(e));
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) drain_one();
    check("drained_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi;
    logic [7:0] b17;
    rst_n = 1'b0; ena = 1'b0; rx_data = '0; rx_bussy = 1'b0; tx_bussy = 1'b0;
    clear_err = 1'b0; exp_ovf = 1'b0; exp_to = 1'b0;
    repeat (3) tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_timeout", 32'(tx_timeout), 32'd0);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();

    // Single byte with latency probe
    rx_data  = 8'h41;
    rx_bussy = 1'b1;
    repeat (4) tick();
    rx_bussy = 1'b0;
    tick();
    tick();
    check("lat_n2_count", 32'(count), 32'd0);
    tick();
    check("lat_n3_count", 32'(count), 32'd1);
    tick();
    check("single_send", 32'(tx_send), 32'd1);
    check("single_data", 32'(tx_data), 32'h41);
    check("single_count", 32'(count), 32'd0);
    tx_bussy = 1'b1;
    wait_send(1'b0, 5, "single_ack");
    check("single_hold", 32'(tx_data), 32'h41);
    tx_bussy = 1'b0;
    repeat (4) tick();
    check("single_idle_send", 32'(tx_send), 32'd0);
    check("single_idle_empty", 32'(empty), 32'd1);

    // Burst behind a stalled transmitter
    tx_bussy = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i), 1'b0);
    check("burst_count", 32'(count), 32'd5);
    drain_all();

    // Random bytes, some arriving while disabled
    n = int'($urandom_range(4, 10));
    for (int i = 0; i < n; i++) begin
      ena = ($urandom_range(0, 3) != 0);
      push_byte(8'($urandom), 1'b0);
    end
    ena = 1'b1;
    check("rand_count", 32'(count), 32'(exp_q.size()));
    drain_all();

    // Overflow, set-wins clear, then simultaneous push/pop at full
    tx_bussy = 1'b0;
    repeat (4) tick();
    tx_bussy = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 17; i++) push_byte(8'($urandom), 1'b0);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'(exp_ovf));
    push_byte(8'($urandom), 1'b1);
    check("ovf_set_wins", 32'(overflow), 32'(exp_ovf));
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'(exp_ovf));
    b17      = 8'($urandom);
    rx_data  = b17;
    rx_bussy = 1'b1;
    repeat (4) tick();
    rx_bussy = 1'b0;
    tx_bussy = 1'b0;
    repeat (3) tick();
    check("simul_send", 32'(tx_send), 32'd1);
    check("simul_count", 32'(count), 32'd16);
    check("simul_overflow", 32'(overflow), 32'd0);
    check("simul_data", 32'(tx_data), 32'(exp_q.pop_front()));
    exp_q.push_back(b17);
    tx_bussy = 1'b1;
    wait_send(1'b0, 6, "simul_ack");
    drain_all();

    // Send timeout: transmitter never answers
    tx_bussy = 1'b0;
    repeat (4) tick();
    rx_data  = 8'($urandom);
    rx_bussy = 1'b1;
    repeat (4) tick();
    rx_bussy = 1'b0;
    repeat (3) tick();
    check("to_count", 32'(count), 32'd1);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tx_send) hi++;
      else if (hi > 0) break;
    end
    exp_to = 1'b1;
    check("to_high_cycles", 32'(hi), 32'(Timeout));
    check("to_flag", 32'(tx_timeout), 32'(exp_to));
    check("to_empty", 32'(empty), 32'd1);
    check("to_send_low", 32'(tx_send), 32'd0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    exp_to = 1'b0;
    check("to_cleared", 32'(tx_timeout), 32'(exp_to));

    // Reset while a request is outstanding
    tx_bussy = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1'b0);
    check("pre_rst_count", 32'(count), 32'd4);
    tx_bussy = 1'b0;
    wait_send(1'b1, 10, "pre_rst_req");
    check("pre_rst_count3", 32'(count), 32'd3);
    rst_n = 1'b0;
    tick();
    check("mid_rst_send", 32'(tx_send), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_to", 32'(tx_timeout), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    tx_bussy = 1'b1;
    repeat (3) tick();
    push_byte(8'($urandom), 1'b0);
    drain_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
